// File: rtl/multicycle_control_if.sv
// Bus bundle between the multi-cycle controller and its datapath/memory side.
// Signal prefixes are from the controller's point of view: i_ enters the
// controller, o_ leaves it.
`timescale 1ns/1ps

interface multicycle_control_if #(
  parameter int ALUOP_W = 2,
  parameter int CNT_W   = 16
);
  logic [10:0]        i_opcode;
  logic               i_zero;
  logic               i_imem_ready;
  logic               i_dmem_ready;

  logic               o_imem_req;
  logic               o_ir_write;
  logic               o_pc_write;
  logic               o_pc_src;
  logic               o_reg2_loc;
  logic               o_uncondbranch;
  logic               o_branch;
  logic               o_mem_read;
  logic               o_mem_to_reg;
  logic               o_mem_write;
  logic               o_alu_src;
  logic               o_reg_write;
  logic [ALUOP_W-1:0] o_alu_op;
  logic [2:0]         o_state;
  logic               o_illegal;
  logic               o_timeout;
  logic [CNT_W-1:0]   o_retired;

  // Controller side
  modport master (
    input  i_opcode, i_zero, i_imem_ready, i_dmem_ready,
    output o_imem_req, o_ir_write, o_pc_write, o_pc_src, o_reg2_loc,
           o_uncondbranch, o_branch, o_mem_read, o_mem_to_reg, o_mem_write,
           o_alu_src, o_reg_write, o_alu_op, o_state, o_illegal, o_timeout,
           o_retired
  );

  // Datapath / memory side
  modport slave (
    output i_opcode, i_zero, i_imem_ready, i_dmem_ready,
    input  o_imem_req, o_ir_write, o_pc_write, o_pc_src, o_reg2_loc,
           o_uncondbranch, o_branch, o_mem_read, o_mem_to_reg, o_mem_write,
           o_alu_src, o_reg_write, o_alu_op, o_state, o_illegal, o_timeout,
           o_retired
  );
endinterface

// File: rtl/multicycle_control.sv
// Multi-cycle control unit for a small LEGv8 subset (ADD/SUB/AND/ORR, LDUR,
// STUR, CBZ, B). Walks FETCH -> DECODE -> EXEC -> [MEM] -> [WB], guards both
// memory waits with a timeout, flags illegal opcodes and counts retirements.
`timescale 1ns/1ps

module multicycle_control #(
  parameter int ALUOP_W = 2,
  parameter int TIMEOUT = 15,
  parameter int CNT_W   = 16
) (
  input  logic                clk,
  input  logic                reset_n,
  multicycle_control_if.master bus
);

  localparam logic [2:0] S_FETCH  = 3'd0;
  localparam logic [2:0] S_DECODE = 3'd1;
  localparam logic [2:0] S_EXEC   = 3'd2;
  localparam logic [2:0] S_MEM    = 3'd3;
  localparam logic [2:0] S_WB     = 3'd4;
  localparam logic [2:0] S_ERR    = 3'd7;

  localparam logic [2:0] C_ILL   = 3'd0;
  localparam logic [2:0] C_RTYPE = 3'd1;
  localparam logic [2:0] C_LDUR  = 3'd2;
  localparam logic [2:0] C_STUR  = 3'd3;
  localparam logic [2:0] C_CBZ   = 3'd4;
  localparam logic [2:0] C_B     = 3'd5;

  localparam logic [ALUOP_W-1:0] ALU_RTYPE  = ALUOP_W'(2'b10);
  localparam logic [ALUOP_W-1:0] ALU_DTYPE  = ALUOP_W'(2'b00);
  localparam logic [ALUOP_W-1:0] ALU_BRANCH = ALUOP_W'(2'b01);

  localparam logic [7:0]       WAIT_LIMIT = 8'(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_MAX    = {CNT_W{1'b1}};

  logic [2:0]         r_state;
  logic [7:0]         r_wait;
  logic [CNT_W-1:0]   r_retired;
  logic               r_illegal;
  logic               r_timeout;

  logic [2:0]         w_class;
  logic [2:0]         w_next;
  logic               w_set_illegal;
  logic               w_set_timeout;

  logic               w_imem_req;
  logic               w_ir_write;
  logic               w_pc_write;
  logic               w_pc_src;
  logic               w_reg2_loc;
  logic               w_uncondbranch;
  logic               w_branch;
  logic               w_mem_read;
  logic               w_mem_to_reg;
  logic               w_mem_write;
  logic               w_alu_src;
  logic               w_reg_write;
  logic [ALUOP_W-1:0] w_alu_op;

  // Classify the instruction register bits; anything unmatched is illegal
  always_comb begin
    w_class = C_ILL;
    casez (bus.i_opcode)
      11'b10001011000,
      11'b11001011000,
      11'b10001010000,
      11'b10101010000: w_class = C_RTYPE;
      11'b11111000010: w_class = C_LDUR;
      11'b11111000000: w_class = C_STUR;
      11'b10110100???: w_class = C_CBZ;
      11'b000101?????: w_class = C_B;
      default:         w_class = C_ILL;
    endcase
  end

  // Next-state selection; a ready strobe at the wait limit beats the timeout
  always_comb begin
    w_next        = r_state;
    w_set_illegal = 1'b0;
    w_set_timeout = 1'b0;
    case (r_state)
      S_FETCH: begin
        if (bus.i_imem_ready) begin
          w_next = S_DECODE;
        end else if (r_wait >= WAIT_LIMIT) begin
          w_next        = S_ERR;
          w_set_timeout = 1'b1;
        end
      end
      S_DECODE: begin
        if (w_class == C_ILL) begin
          w_next        = S_ERR;
          w_set_illegal = 1'b1;
        end else begin
          w_next = S_EXEC;
        end
      end
      S_EXEC: begin
        case (w_class)
          C_RTYPE:        w_next = S_WB;
          C_LDUR, C_STUR: w_next = S_MEM;
          default:        w_next = S_FETCH;
        endcase
      end
      S_MEM: begin
        if (bus.i_dmem_ready) begin
          w_next = (w_class == C_LDUR) ? S_WB : S_FETCH;
        end else if (r_wait >= WAIT_LIMIT) begin
          w_next        = S_ERR;
          w_set_timeout = 1'b1;
        end
      end
      S_WB:    w_next = S_FETCH;
      S_ERR:   w_next = S_ERR;
      default: w_next = S_FETCH;
    endcase
  end

  // Datapath controls, decoded from the current state and instruction class
  always_comb begin
    w_imem_req     = 1'b0;
    w_ir_write     = 1'b0;
    w_pc_write     = 1'b0;
    w_pc_src       = 1'b0;
    w_reg2_loc     = 1'b0;
    w_uncondbranch = 1'b0;
    w_branch       = 1'b0;
    w_mem_read     = 1'b0;
    w_mem_to_reg   = 1'b0;
    w_mem_write    = 1'b0;
    w_alu_src      = 1'b0;
    w_reg_write    = 1'b0;
    w_alu_op       = '0;
    case (r_state)
      S_FETCH: begin
        w_imem_req = 1'b1;
        w_ir_write = bus.i_imem_ready;
      end
      S_EXEC: begin
        case (w_class)
          C_RTYPE: w_alu_op = ALU_RTYPE;
          C_LDUR: begin
            w_alu_op  = ALU_DTYPE;
            w_alu_src = 1'b1;
          end
          C_STUR: begin
            w_alu_op   = ALU_DTYPE;
            w_alu_src  = 1'b1;
            w_reg2_loc = 1'b1;
          end
          C_CBZ: begin
            w_alu_op   = ALU_BRANCH;
            w_reg2_loc = 1'b1;
            w_branch   = 1'b1;
            w_pc_write = 1'b1;
            w_pc_src   = bus.i_zero;
          end
          C_B: begin
            w_uncondbranch = 1'b1;
            w_pc_write     = 1'b1;
            w_pc_src       = 1'b1;
          end
          default: ;
        endcase
      end
      S_MEM: begin
        if (w_class == C_LDUR) begin
          w_mem_read = 1'b1;
        end else if (w_class == C_STUR) begin
          w_mem_write = 1'b1;
          w_pc_write  = bus.i_dmem_ready;
        end
      end
      S_WB: begin
        w_reg_write  = 1'b1;
        w_mem_to_reg = (w_class == C_LDUR);
        w_pc_write   = 1'b1;
      end
      default: ;
    endcase
  end

  // State, wait counter, sticky error flags and saturating retire count
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= S_FETCH;
      r_wait    <= 8'd0;
      r_retired <= '0;
      r_illegal <= 1'b0;
      r_timeout <= 1'b0;
    end else begin
      r_state <= w_next;
      if ((w_next == S_FETCH || w_next == S_MEM) && w_next == r_state) begin
        r_wait <= r_wait + 8'd1;
      end else begin
        r_wait <= 8'd0;
      end
      if (w_pc_write && r_retired != CNT_MAX) begin
        r_retired <= r_retired + CNT_W'(1);
      end
      if (w_set_illegal) begin
        r_illegal <= 1'b1;
      end
      if (w_set_timeout) begin
        r_timeout <= 1'b1;
      end
    end
  end

  assign bus.o_imem_req     = w_imem_req;
  assign bus.o_ir_write     = w_ir_write;
  assign bus.o_pc_write     = w_pc_write;
  assign bus.o_pc_src       = w_pc_src;
  assign bus.o_reg2_loc     = w_reg2_loc;
  assign bus.o_uncondbranch = w_uncondbranch;
  assign bus.o_branch       = w_branch;
  assign bus.o_mem_read     = w_mem_read;
  assign bus.o_mem_to_reg   = w_mem_to_reg;
  assign bus.o_mem_write    = w_mem_write;
  assign bus.o_alu_src      = w_alu_src;
  assign bus.o_reg_write    = w_reg_write;
  assign bus.o_alu_op       = w_alu_op;
  assign bus.o_state        = r_state;
  assign bus.o_illegal      = r_illegal;
  assign bus.o_timeout      = r_timeout;
  assign bus.o_retired      = r_retired;

endmodule

// File: tb/tb_multicycle_control.sv
// Directed testbench for multicycle_control. Small wait limit and a 3-bit
// retire counter so the timeout and saturation corners are reachable quickly.
`timescale 1ns/1ps

module tb_multicycle_control;

  localparam logic [10:0] OP_ADD  = 11'b10001011000;
  localparam logic [10:0] OP_SUB  = 11'b11001011000;
  localparam logic [10:0] OP_AND  = 11'b10001010000;
  localparam logic [10:0] OP_ORR  = 11'b10101010000;
  localparam logic [10:0] OP_LDUR = 11'b11111000010;
  localparam logic [10:0] OP_STUR = 11'b11111000000;
  localparam logic [10:0] OP_CBZ  = 11'b10110100101;
  localparam logic [10:0] OP_B    = 11'b00010111010;
  localparam logic [10:0] OP_BAD  = 11'b11111111111;
  localparam logic [10:0] OP_NEAR = 11'b10001011001;

  // Bit positions of the packed control vector below
  localparam logic [13:0] IMEM  = 14'h2000;
  localparam logic [13:0] IRW   = 14'h1000;
  localparam logic [13:0] PCW   = 14'h0800;
  localparam logic [13:0] PCS   = 14'h0400;
  localparam logic [13:0] R2L   = 14'h0200;
  localparam logic [13:0] UB    = 14'h0100;
  localparam logic [13:0] BR    = 14'h0080;
  localparam logic [13:0] MR    = 14'h0040;
  localparam logic [13:0] M2R   = 14'h0020;
  localparam logic [13:0] MW    = 14'h0010;
  localparam logic [13:0] ASRC  = 14'h0008;
  localparam logic [13:0] RW    = 14'h0004;
  localparam logic [13:0] AOP_R = 14'h0002;
  localparam logic [13:0] AOP_B = 14'h0001;
  localparam logic [13:0] NONE  = 14'h0000;

  logic        clk;
  logic        resetN;
  logic [13:0] ctl;
  logic [1:0]  flg;
  int          nChecks = 0;
  int          nFail   = 0;

  multicycle_control_if #(.ALUOP_W(2), .CNT_W(3)) bus ();

  multicycle_control #(.ALUOP_W(2), .TIMEOUT(4), .CNT_W(3)) dut (
    .clk     (clk),
    .reset_n (resetN),
    .bus     (bus)
  );

  assign ctl = {bus.o_imem_req, bus.o_ir_write, bus.o_pc_write, bus.o_pc_src,
                bus.o_reg2_loc, bus.o_uncondbranch, bus.o_branch, bus.o_mem_read,
                bus.o_mem_to_reg, bus.o_mem_write, bus.o_alu_src, bus.o_reg_write,
                bus.o_alu_op};
  assign flg = {bus.o_illegal, bus.o_timeout};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hard stop in case something stalls the sequence
  initial begin
    #100000;
    $display("[TB] FAIL watchdog: time limit reached before summary, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  // Inputs change at the falling edge; outputs are read 1 ns later
  task automatic drive(input logic [10:0] op, input logic z, input logic im, input logic dm);
    bus.i_opcode     = op;
    bus.i_zero       = z;
    bus.i_imem_ready = im;
    bus.i_dmem_ready = dm;
    #1;
  endtask

  // Reset pulse that returns at a falling edge with reset released
  task automatic applyStimulus_reset();
    @(negedge clk);
    resetN = 1'b0;
    drive(11'd0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    resetN = 1'b1;
  endtask

  task automatic test_reset();
    drive(11'd0, 1'b0, 1'b0, 1'b0);
    resetN = 1'b0;
    #2;
    nChecks++;
    if (bus.o_state !== 3'd0 || (ctl & ~IMEM) !== NONE || bus.o_retired !== 3'd0 || flg !== 2'b00) begin
      nFail++;
      $display("[TB] FAIL reset_hold: state=%0d ctl=%h retired=%0d flags=%b, want state=0 ctl(no imem)=0 retired=0 flags=00",
               bus.o_state, ctl & ~IMEM, bus.o_retired, flg);
    end
    @(negedge clk);
    resetN = 1'b1;
    drive(11'd0, 1'b0, 1'b0, 1'b0);
    nChecks++;
    if (bus.o_state !== 3'd0 || ctl !== IMEM) begin
      nFail++;
      $display("[TB] FAIL first_fetch: state=%0d ctl=%h, want state=0 ctl=%h", bus.o_state, ctl, IMEM);
    end
    @(negedge clk);
    drive(11'd0, 1'b0, 1'b0, 1'b0);
    nChecks++;
    if (bus.o_state !== 3'd0 || ctl !== IMEM || bus.o_retired !== 3'd0) begin
      nFail++;
      $display("[TB] FAIL fetch_hold: state=%0d ctl=%h retired=%0d, want state=0 ctl=%h retired=0",
               bus.o_state, ctl, bus.o_retired, IMEM);
    end
  endtask

  task automatic test_rtype();
    logic        im   [5];
    logic [2:0]  eSt  [5];
    logic [13:0] eCtl [5];
    logic [2:0]  eRet [5];
    im   = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    eSt  = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd0};
    eCtl = '{IMEM | IRW, NONE, AOP_R, RW | PCW, IMEM};
    eRet = '{3'd0, 3'd0, 3'd0, 3'd0, 3'd1};
    applyStimulus_reset();
    for (int i = 0; i < 5; i++) begin
      drive(OP_ADD, 1'b0, im[i], 1'b0);
      nChecks++;
      if (bus.o_state !== eSt[i] || ctl !== eCtl[i] || bus.o_retired !== eRet[i] || flg !== 2'b00) begin
        nFail++;
        $display("[TB] FAIL add row %0d: state=%0d ctl=%h retired=%0d flags=%b, want state=%0d ctl=%h retired=%0d flags=00",
                 i, bus.o_state, ctl, bus.o_retired, flg, eSt[i], eCtl[i], eRet[i]);
      end
      @(negedge clk);
    end
  endtask

  // Both ready strobes held high: only FETCH may react to them
  task automatic test_ignore_ready();
    logic [10:0] ops  [3];
    logic [2:0]  eSt  [4];
    logic [13:0] eCtl [4];
    ops  = '{OP_SUB, OP_AND, OP_ORR};
    eSt  = '{3'd0, 3'd1, 3'd2, 3'd4};
    eCtl = '{IMEM | IRW, NONE, AOP_R, RW | PCW};
    applyStimulus_reset();
    for (int i = 0; i < 12; i++) begin
      drive(ops[i / 4], 1'b0, 1'b1, 1'b1);
      nChecks++;
      if (bus.o_state !== eSt[i % 4] || ctl !== eCtl[i % 4] || bus.o_retired !== 3'(i / 4)) begin
        nFail++;
        $display("[TB] FAIL rtype_ready row %0d: state=%0d ctl=%h retired=%0d, want state=%0d ctl=%h retired=%0d",
                 i, bus.o_state, ctl, bus.o_retired, eSt[i % 4], eCtl[i % 4], i / 4);
      end
      @(negedge clk);
    end
    drive(OP_SUB, 1'b0, 1'b0, 1'b0);
    nChecks++;
    if (bus.o_state !== 3'd0 || bus.o_retired !== 3'd3) begin
      nFail++;
      $display("[TB] FAIL rtype_ready_end: state=%0d retired=%0d, want state=0 retired=3", bus.o_state, bus.o_retired);
    end
  endtask

  task automatic test_load_store();
    logic        im   [14];
    logic        dm   [14];
    logic [2:0]  eSt  [14];
    logic [13:0] eCtl [14];
    logic [2:0]  eRet [14];
    im   = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    dm   = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    eSt  = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd3, 3'd3, 3'd3, 3'd4, 3'd0, 3'd1, 3'd2, 3'd3, 3'd3, 3'd0};
    eCtl = '{IMEM | IRW, NONE, ASRC, MR, MR, MR, MR, RW | M2R | PCW,
             IMEM | IRW, NONE, ASRC | R2L, MW, MW | PCW, IMEM};
    eRet = '{3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd1, 3'd1, 3'd1, 3'd1, 3'd1, 3'd2};
    applyStimulus_reset();
    for (int i = 0; i < 14; i++) begin
      drive((i < 8) ? OP_LDUR : OP_STUR, 1'b0, im[i], dm[i]);
      nChecks++;
      if (bus.o_state !== eSt[i] || ctl !== eCtl[i] || bus.o_retired !== eRet[i] || flg !== 2'b00) begin
        nFail++;
        $display("[TB] FAIL ldst row %0d: state=%0d ctl=%h retired=%0d flags=%b, want state=%0d ctl=%h retired=%0d flags=00",
                 i, bus.o_state, ctl, bus.o_retired, flg, eSt[i], eCtl[i], eRet[i]);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_branches();
    logic        z    [10];
    logic        im   [10];
    logic [2:0]  eSt  [10];
    logic [13:0] eCtl [10];
    logic [2:0]  eRet [10];
    z    = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    im   = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    eSt  = '{3'd0, 3'd1, 3'd2, 3'd0, 3'd1, 3'd2, 3'd0, 3'd1, 3'd2, 3'd0};
    eCtl = '{IMEM | IRW, NONE, R2L | BR | PCW | PCS | AOP_B,
             IMEM | IRW, NONE, R2L | BR | PCW | AOP_B,
             IMEM | IRW, NONE, UB | PCW | PCS, IMEM};
    eRet = '{3'd0, 3'd0, 3'd0, 3'd1, 3'd1, 3'd1, 3'd2, 3'd2, 3'd2, 3'd3};
    applyStimulus_reset();
    for (int i = 0; i < 10; i++) begin
      drive((i < 6) ? OP_CBZ : OP_B, z[i], im[i], 1'b0);
      nChecks++;
      if (bus.o_state !== eSt[i] || ctl !== eCtl[i] || bus.o_retired !== eRet[i] || flg !== 2'b00) begin
        nFail++;
        $display("[TB] FAIL branch row %0d: state=%0d ctl=%h retired=%0d flags=%b, want state=%0d ctl=%h retired=%0d flags=00",
                 i, bus.o_state, ctl, bus.o_retired, flg, eSt[i], eCtl[i], eRet[i]);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_illegal();
    logic        im   [7];
    logic        dm   [7];
    logic [2:0]  eSt  [7];
    logic [13:0] eCtl [7];
    logic [1:0]  eFlg [7];
    im   = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    dm   = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    eSt  = '{3'd0, 3'd1, 3'd7, 3'd7, 3'd7, 3'd7, 3'd7};
    eCtl = '{IMEM | IRW, NONE, NONE, NONE, NONE, NONE, NONE};
    eFlg = '{2'b00, 2'b00, 2'b10, 2'b10, 2'b10, 2'b10, 2'b10};
    applyStimulus_reset();
    for (int i = 0; i < 7; i++) begin
      drive(OP_BAD, 1'b0, im[i], dm[i]);
      nChecks++;
      if (bus.o_state !== eSt[i] || ctl !== eCtl[i] || bus.o_retired !== 3'd0 || flg !== eFlg[i]) begin
        nFail++;
        $display("[TB] FAIL illegal row %0d: state=%0d ctl=%h retired=%0d flags=%b, want state=%0d ctl=%h retired=0 flags=%b",
                 i, bus.o_state, ctl, bus.o_retired, flg, eSt[i], eCtl[i], eFlg[i]);
      end
      @(negedge clk);
    end
    // Reset pulled while sitting in ERR must clear everything at once
    drive(OP_BAD, 1'b0, 1'b0, 1'b0);
    resetN = 1'b0;
    #1;
    nChecks++;
    if (bus.o_state !== 3'd0 || flg !== 2'b00 || (ctl & ~IMEM) !== NONE) begin
      nFail++;
      $display("[TB] FAIL err_reset: state=%0d flags=%b ctl=%h, want state=0 flags=00 ctl(no imem)=0",
               bus.o_state, flg, ctl & ~IMEM);
    end
    @(negedge clk);
    resetN = 1'b1;
    // One bit away from ADD is still illegal
    drive(OP_NEAR, 1'b0, 1'b1, 1'b0);
    @(negedge clk);
    drive(OP_NEAR, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    drive(OP_NEAR, 1'b0, 1'b0, 1'b0);
    nChecks++;
    if (bus.o_state !== 3'd7 || flg !== 2'b10) begin
      nFail++;
      $display("[TB] FAIL near_miss: state=%0d flags=%b, want state=7 flags=10", bus.o_state, flg);
    end
  endtask

  task automatic test_fetch_timeout();
    logic [2:0]  eSt  [7];
    logic [13:0] eCtl [7];
    logic [1:0]  eFlg [7];
    eSt  = '{3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd7, 3'd7};
    eCtl = '{IMEM, IMEM, IMEM, IMEM, IMEM, NONE, NONE};
    eFlg = '{2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b01, 2'b01};
    applyStimulus_reset();
    for (int i = 0; i < 7; i++) begin
      drive(OP_ADD, 1'b0, (i == 6), 1'b0);
      nChecks++;
      if (bus.o_state !== eSt[i] || ctl !== eCtl[i] || flg !== eFlg[i]) begin
        nFail++;
        $display("[TB] FAIL fetch_timeout row %0d: state=%0d ctl=%h flags=%b, want state=%0d ctl=%h flags=%b",
                 i, bus.o_state, ctl, flg, eSt[i], eCtl[i], eFlg[i]);
      end
      @(negedge clk);
    end
  endtask

  // Ready exactly at the limit cycle, twice, to see the counter restart
  task automatic test_ready_at_limit();
    logic        im   [13];
    logic [2:0]  eSt  [13];
    logic [13:0] eCtl [13];
    logic [2:0]  eRet [13];
    im   = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    eSt  = '{3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd1, 3'd2, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd1};
    eCtl = '{IMEM, IMEM, IMEM, IMEM, IMEM | IRW, NONE, UB | PCW | PCS,
             IMEM, IMEM, IMEM, IMEM, IMEM | IRW, NONE};
    eRet = '{3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd1, 3'd1, 3'd1, 3'd1, 3'd1, 3'd1};
    applyStimulus_reset();
    for (int i = 0; i < 13; i++) begin
      drive(OP_B, 1'b0, im[i], 1'b0);
      nChecks++;
      if (bus.o_state !== eSt[i] || ctl !== eCtl[i] || bus.o_retired !== eRet[i] || flg !== 2'b00) begin
        nFail++;
        $display("[TB] FAIL ready_limit row %0d: state=%0d ctl=%h retired=%0d flags=%b, want state=%0d ctl=%h retired=%0d flags=00",
                 i, bus.o_state, ctl, bus.o_retired, flg, eSt[i], eCtl[i], eRet[i]);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_mem_timeout();
    logic [2:0]  eSt  [10];
    logic [13:0] eCtl [10];
    logic [1:0]  eFlg [10];
    eSt  = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd3, 3'd3, 3'd3, 3'd3, 3'd7, 3'd7};
    eCtl = '{IMEM | IRW, NONE, ASRC, MR, MR, MR, MR, MR, NONE, NONE};
    eFlg = '{2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b01, 2'b01};
    applyStimulus_reset();
    for (int i = 0; i < 10; i++) begin
      drive(OP_LDUR, 1'b0, (i == 0), (i == 9));
      nChecks++;
      if (bus.o_state !== eSt[i] || ctl !== eCtl[i] || flg !== eFlg[i] || bus.o_retired !== 3'd0) begin
        nFail++;
        $display("[TB] FAIL mem_timeout row %0d: state=%0d ctl=%h flags=%b retired=%0d, want state=%0d ctl=%h flags=%b retired=0",
                 i, bus.o_state, ctl, flg, bus.o_retired, eSt[i], eCtl[i], eFlg[i]);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset_mid_mem();
    applyStimulus_reset();
    drive(OP_LDUR, 1'b0, 1'b1, 1'b0);
    @(negedge clk);
    drive(OP_LDUR, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    drive(OP_LDUR, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    drive(OP_LDUR, 1'b0, 1'b0, 1'b0);
    nChecks++;
    if (bus.o_state !== 3'd3 || ctl !== MR) begin
      nFail++;
      $display("[TB] FAIL mid_mem_setup: state=%0d ctl=%h, want state=3 ctl=%h", bus.o_state, ctl, MR);
    end
    #2;
    resetN = 1'b0;
    #1;
    nChecks++;
    if (bus.o_state !== 3'd0 || bus.o_mem_read !== 1'b0 || (ctl & ~IMEM) !== NONE || bus.o_retired !== 3'd0) begin
      nFail++;
      $display("[TB] FAIL mid_mem_reset: state=%0d mem_read=%b ctl=%h retired=%0d, want state=0 mem_read=0 ctl(no imem)=0 retired=0",
               bus.o_state, bus.o_mem_read, ctl & ~IMEM, bus.o_retired);
    end
    @(negedge clk);
    resetN = 1'b1;
    drive(OP_LDUR, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    drive(OP_LDUR, 1'b0, 1'b0, 1'b0);
    nChecks++;
    if (bus.o_state !== 3'd0 || ctl !== IMEM || bus.o_retired !== 3'd0) begin
      nFail++;
      $display("[TB] FAIL mid_mem_release: state=%0d ctl=%h retired=%0d, want state=0 ctl=%h retired=0",
               bus.o_state, ctl, bus.o_retired, IMEM);
    end
  endtask

  // Nine B fetches: eight retire, the 3-bit count must stop at 7
  task automatic test_saturation();
    logic [2:0] expRet;
    applyStimulus_reset();
    for (int k = 0; k < 9; k++) begin
      drive(OP_B, 1'b0, 1'b1, 1'b0);
      expRet = (k > 7) ? 3'd7 : 3'(k);
      nChecks++;
      if (bus.o_state !== 3'd0 || bus.o_retired !== expRet) begin
        nFail++;
        $display("[TB] FAIL saturate fetch %0d: state=%0d retired=%0d, want state=0 retired=%0d",
                 k, bus.o_state, bus.o_retired, expRet);
      end
      @(negedge clk);
      if (k < 8) begin
        drive(OP_B, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        drive(OP_B, 1'b0, 1'b0, 1'b0);
        nChecks++;
        if (bus.o_state !== 3'd2 || ctl !== (UB | PCW | PCS)) begin
          nFail++;
          $display("[TB] FAIL saturate exec %0d: state=%0d ctl=%h, want state=2 ctl=%h",
                   k, bus.o_state, ctl, UB | PCW | PCS);
        end
        @(negedge clk);
      end
    end
  endtask

  initial begin
    resetN = 1'b1;
    test_reset();
    test_rtype();
    test_ignore_ready();
    test_load_store();
    test_branches();
    test_illegal();
    test_fetch_timeout();
    test_ready_at_limit();
    test_mem_timeout();
    test_reset_mid_mem();
    test_saturation();
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
    $finish;
  end

endmodule

// File: doc/multicycle_control.md
MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
- REQ-001 Parameter ALUOP_W, default 2: width of alu_op.
- REQ-002 Parameter TIMEOUT, default 15: maximum wait cycles for imem_ready/dmem_ready; legal range 1..255.
- REQ-003 Parameter CNT_W, default 16: width of retired-instruction counter.
- REQ-004 clk  in  1  single clock; all state updates on rising edge.
- REQ-005 reset_n  in  1  asynchronous, active-low reset.
- REQ-006 opcode  in  11  instruction bits [31:21] from instruction register; stable from DECODE until FETCH.
- REQ-007 zero  in  1  ALU zero flag, sampled in EXEC.
- REQ-008 imem_ready, dmem_ready  in  1 each  memory completion strobes.
- REQ-009 imem_req  out  1  instruction fetch request.
- REQ-010 ir_write, pc_write, pc_src  out  1 each  IR load strobe, PC load strobe, 1 = branch target / 0 = PC+4.
- REQ-011 reg2_loc, uncondbranch, branch, mem_read, mem_to_reg, mem_write, alu_src, reg_write  out  1 each  datapath controls.
- REQ-012 alu_op  out  ALUOP_W  RTYPE=2'b10, DTYPE=2'b00, BRANCH=2'b01, zero-extended when ALUOP_W>2.
- REQ-013 state  out  3  FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, ERR=7.
- REQ-014 illegal, timeout  out  1 each  sticky error flags.
- REQ-015 retired  out  CNT_W  count of completed instructions.

Function
- REQ-016 Decode: ADD 10001011000, SUB 11001011000, AND 10001010000, ORR 10101010000, LDUR 11111000010, STUR 11111000000, CBZ 10110100xxx, B 000101xxxxx (x = don't care); any other value is illegal.
- REQ-017 FETCH: imem_req=1; on imem_ready, ir_write=1 for that cycle only and next state DECODE.
- REQ-018 DECODE: all strobes 0; illegal opcode -> ERR with illegal set; otherwise -> EXEC.
- REQ-019 EXEC, R-type: alu_op=RTYPE, alu_src=0, reg2_loc=0 -> WB.
- REQ-020 EXEC, LDUR/STUR: alu_op=DTYPE, alu_src=1, and reg2_loc=1 for STUR -> MEM.
- REQ-021 EXEC, CBZ: alu_op=BRANCH, reg2_loc=1, branch=1, pc_write=1, pc_src=zero -> FETCH.
- REQ-022 EXEC, B: uncondbranch=1, pc_write=1, pc_src=1 -> FETCH.
- REQ-023 MEM: mem_read=1 (LDUR) or mem_write=1 (STUR), held until dmem_ready; on dmem_ready LDUR -> WB, STUR -> FETCH with pc_write=1, pc_src=0.
- REQ-024 WB: reg_write=1, mem_to_reg=1 for LDUR else 0, pc_write=1, pc_src=0 -> FETCH.
- REQ-025 Every non-listed output SHALL be 0 in each state; pc_write SHALL be 1 in exactly one cycle per instruction.
- REQ-026 retired increments by 1 in every cycle with pc_write=1; saturates at all-ones.
- REQ-027 Wait counter: cleared on entry to FETCH/MEM; increments each cycle the ready strobe is low; the cycle it would exceed TIMEOUT -> ERR with timeout set.
- REQ-028 A ready strobe arriving in the same cycle as the timeout limit wins: normal transition, no error.
- REQ-029 ERR is absorbing: all strobes 0, flags held, exit only via reset.
- REQ-030 Ready strobes outside their owning state are ignored.

Reset
- REQ-031 reset_n low asynchronously forces state=FETCH, wait counter=0, retired=0, illegal=0, timeout=0, with all outputs 0 except imem_req, which reflects FETCH after release.
- REQ-032 Reset asserted mid-instruction (any state, including ERR) aborts it with no pc_write and no retired increment.
- REQ-033 First imem_req SHALL appear in the first clock after reset_n deasserts.

Verification
- REQ-034 ADD, imem_ready in cycle 1 -> states 0,1,2,4,0; reg_write and pc_write high in WB only; retired=1.
- REQ-035 LDUR, dmem_ready after 3 MEM cycles -> mem_read high 4 cycles, WB with mem_to_reg=1; STUR -> no WB, pc_write in last MEM cycle.
- REQ-036 CBZ with zero=1 then zero=0 -> pc_src 1 then 0, 3-cycle instructions, retired=2.
- REQ-037 opcode 11111111111 -> ERR after DECODE, illegal=1; imem_ready pulses -> no change.
- REQ-038 TIMEOUT=4, imem_ready never -> timeout=1 at the 5th FETCH cycle; ready on the 4th wait cycle -> no error.
- REQ-039 reset_n pulsed low during MEM -> immediate state=0, mem_read=0, retired unchanged at 0 from reset.
